// File: rtl/cam_cfg_pkg.sv
// Shared types, constants and the default OV7670 QVGA RGB565 register table for the
// camera configuration sequencer (optional NACK retry: CAM_CFG_RETRY_EN).
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [7:0]  COM7_ADDR      = 8'h12;
  localparam int          COM7_RESET_BIT = 7;
  localparam logic [15:0] SENTINEL       = 16'hFFFF;
  localparam int          TABLE_LEN      = 24;

  // Entry 0 sits in the most significant slot; soft reset first, then QVGA RGB565.
  localparam cfg_entry_t [0:TABLE_LEN-1] DEFAULT_TABLE = {
    16'h1280, 16'h1214, 16'h1101, 16'h40D0, 16'h8C00, 16'h3A04,
    16'h0C04, 16'h3E19, 16'h703A, 16'h7135, 16'h7211, 16'h73F1,
    16'hA202, 16'h1716, 16'h1804, 16'h3224, 16'h1902, 16'h1A7A,
    16'h030A, 16'h13E7, 16'h4F80, 16'h5080, 16'h5100, 16'h589E
  };

  function automatic logic is_soft_reset(input cfg_entry_t e);
    return (e.reg_addr == COM7_ADDR) && e.data[COM7_RESET_BIT];
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Combinational register-table lookup; indices beyond the table return the sentinel.
module cam_cfg_rom import cam_cfg_pkg::*; #(
  parameter int                        IDX_W = 5,
  parameter logic [16*TABLE_LEN-1:0]   TABLE = DEFAULT_TABLE
) (
  input  logic [IDX_W-1:0] index,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = cfg_entry_t'(SENTINEL);
    for (int i = 0; i < TABLE_LEN; i++) begin
      if (int'(index) == i) begin
        entry = cfg_entry_t'(TABLE[(TABLE_LEN-1-i)*16 +: 16]);
      end
    end
  end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// OV7670 power-up configuration sequencer: walks the register table and issues one SCCB
// write per entry with settle delays. Define CAM_CFG_RETRY_EN to resend NACKed entries.
module cam_cfg_sequencer import cam_cfg_pkg::*; #(
  parameter int                      NUM_REGS          = 24,
  parameter logic [7:0]              DEV_ADDR          = 8'h42,
  parameter int                      RESET_WAIT_CYCLES = 1_000_000,
  parameter int                      INTER_WAIT_CYCLES = 1_000,
  parameter int                      MAX_RETRIES       = 3,
  parameter logic [16*TABLE_LEN-1:0] TABLE             = DEFAULT_TABLE,
  localparam int                     IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             wr_req,
  input  logic             wr_ready,
  output logic [7:0]       wr_dev,
  output logic [7:0]       wr_reg,
  output logic [7:0]       wr_data,
  input  logic             wr_done,
  input  logic             wr_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int SEQ_W = $clog2(NUM_REGS + 1);
  localparam int CNT_W = $clog2(RESET_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RESET_WAIT = CNT_W'(RESET_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] INTER_WAIT = CNT_W'(INTER_WAIT_CYCLES);
  localparam logic [SEQ_W-1:0] LAST_IDX   = SEQ_W'(NUM_REGS);

  state_t           state;
  logic [SEQ_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] settle_len;
  cfg_entry_t       entry;
  logic             retry_ok;

  cam_cfg_rom #(
    .IDX_W (IDX_W),
    .TABLE (TABLE)
  ) u_rom (
    .index (idx[IDX_W-1:0]),
    .entry (entry)
  );

  assign settle_len = is_soft_reset({wr_reg, wr_data}) ? RESET_WAIT : INTER_WAIT;

`ifdef CAM_CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RTY_W-1:0] retry_cnt;

  assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE || state == ST_ERROR) && start) begin
      retry_cnt <= '0;
    end else if (state == ST_WAIT_DONE && wr_done) begin
      if (!wr_nack)      retry_cnt <= '0;
      else if (retry_ok) retry_cnt <= retry_cnt + RTY_W'(1);
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      wr_req    <= 1'b0;
      wr_dev    <= '0;
      wr_reg    <= '0;
      wr_data   <= '0;
      err_index <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            idx   <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (idx == LAST_IDX || entry == SENTINEL) begin
            state <= ST_DONE;
          end else begin
            wr_dev  <= DEV_ADDR;
            wr_reg  <= entry.reg_addr;
            wr_data <= entry.data;
            wr_req  <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wr_req && wr_ready) begin
            wr_req <= 1'b0;
            state  <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (wr_done) begin
            if (!wr_nack) begin
              // A zero-length settle skips SETTLE so its length stays exact.
              if (settle_len == '0) begin
                idx   <= idx + SEQ_W'(1);
                state <= ST_FETCH;
              end else begin
                wait_cnt <= settle_len;
                state    <= ST_SETTLE;
              end
            end else if (retry_ok) begin
              wr_req <= 1'b1;
              state  <= ST_ISSUE;
            end else begin
              err_index <= idx[IDX_W-1:0];
              state     <= ST_ERROR;
            end
          end
        end
        ST_SETTLE: begin
          if (wait_cnt == CNT_W'(1)) begin
            wait_cnt <= '0;
            idx      <= idx + SEQ_W'(1);
            state    <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = state inside {ST_FETCH, ST_ISSUE, ST_WAIT_DONE, ST_SETTLE};
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer: a 4-entry table instance plus a sentinel-table instance.
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam logic [16*TABLE_LEN-1:0] TB_TABLE =
    {16'h1280, 16'h1101, 16'h3A04, 16'h40D0, {(TABLE_LEN-4){16'hFFFF}}};
  localparam logic [16*TABLE_LEN-1:0] SENT_TABLE =
    {16'h1101, 16'h3A04, 16'hFFFF, 16'h40D0, {(TABLE_LEN-4){16'hFFFF}}};

  logic       clk = 1'b0;
  logic       reset, start, wr_ready;
  logic       wr_req, busy, done, error;
  logic [7:0] wr_dev, wr_reg, wr_data;
  logic       wr_done = 1'b0, wr_nack = 1'b0;
  logic [1:0] err_index;

  logic       start_s;
  logic       wr_req_s, busy_s, done_s, error_s, wr_ready_s, wr_nack_s;
  logic [7:0] wr_dev_s, wr_reg_s, wr_data_s;
  logic       wr_done_s = 1'b0;
  logic [1:0] err_index_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_reg  [4] = '{8'h12, 8'h11, 8'h3A, 8'h40};
  logic [7:0] exp_data [4] = '{8'h80, 8'h01, 8'h04, 8'hD0};
  int         exp_gap  [3] = '{12, 5, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_cfg_sequencer #(
    .NUM_REGS(4), .DEV_ADDR(8'h42), .RESET_WAIT_CYCLES(10), .INTER_WAIT_CYCLES(3),
    .MAX_RETRIES(3), .TABLE(TB_TABLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_req(wr_req), .wr_ready(wr_ready),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data), .wr_done(wr_done),
    .wr_nack(wr_nack), .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  cam_cfg_sequencer #(
    .NUM_REGS(4), .DEV_ADDR(8'h42), .RESET_WAIT_CYCLES(10), .INTER_WAIT_CYCLES(3),
    .MAX_RETRIES(3), .TABLE(SENT_TABLE)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .wr_req(wr_req_s), .wr_ready(wr_ready_s),
    .wr_dev(wr_dev_s), .wr_reg(wr_reg_s), .wr_data(wr_data_s), .wr_done(wr_done_s),
    .wr_nack(wr_nack_s), .busy(busy_s), .done(done_s), .error(error_s), .err_index(err_index_s)
  );

  // SCCB master model: accepts on wr_req && wr_ready, answers two cycles later.
  bit         pend;
  int         lat;
  bit         cur_nack;
  logic [7:0] nack_reg = 8'h00;
  int         nack_left = 0;
  logic [7:0] log_reg[$], log_data[$], log_dev[$];
  int         req_cyc[$], done_cyc[$];

  always @(negedge clk) begin
    wr_done = 1'b0;
    wr_nack = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (lat == 0) begin
        wr_done = 1'b1;
        wr_nack = cur_nack;
        pend = 1'b0;
        done_cyc.push_back(cyc);
      end else begin
        lat--;
      end
    end else if (wr_req && wr_ready) begin
      log_reg.push_back(wr_reg);
      log_data.push_back(wr_data);
      log_dev.push_back(wr_dev);
      req_cyc.push_back(cyc);
      cur_nack = (nack_left > 0) && (wr_reg == nack_reg);
      if (cur_nack) nack_left--;
      pend = 1'b1;
      lat = 1;
    end
  end

  assign wr_ready_s = 1'b1;
  assign wr_nack_s  = 1'b0;
  bit pend_s;
  int lat_s;
  int nwr_s = 0;

  always @(negedge clk) begin
    wr_done_s = 1'b0;
    if (reset) begin
      pend_s = 1'b0;
    end else if (pend_s) begin
      if (lat_s == 0) begin
        wr_done_s = 1'b1;
        pend_s = 1'b0;
      end else begin
        lat_s--;
      end
    end else if (wr_req_s) begin
      nwr_s++;
      pend_s = 1'b1;
      lat_s = 1;
    end
  end

  task automatic clear_logs();
    log_reg.delete(); log_data.delete(); log_dev.delete();
    req_cyc.delete(); done_cyc.delete();
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_s = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b expected 0", wr_req); end
    checks++;
    if ({wr_dev, wr_reg, wr_data} !== 24'h0) begin
      errors++; $display("FAIL reset_wr_bus: got %h expected 000000", {wr_dev, wr_reg, wr_data});
    end
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, error});
    end
    checks++;
    if (err_index !== 2'd0) begin errors++; $display("FAIL reset_err_index: got %0d expected 0", err_index); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || log_reg.size() != 0) begin
      errors++; $display("FAIL idle_without_start: busy %b writes %0d expected 0 0", busy, log_reg.size());
    end
  endtask

  task automatic test_normal();
    int t0;
    bit ok;
    clear_logs();
    pulse_start(t0);
    wait_end(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL normal_timeout: got no end expected done"); end
    checks++;
    if ({done, error, busy} !== 3'b100) begin
      errors++; $display("FAIL normal_status: got done/error/busy %b expected 100", {done, error, busy});
    end
    checks++;
    if (log_reg.size() != 4) begin
      errors++; $display("FAIL normal_count: got %0d writes expected 4", log_reg.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_reg[i] !== exp_reg[i] || log_data[i] !== exp_data[i] || log_dev[i] !== 8'h42) begin
          errors++;
          $display("FAIL normal_entry%0d: got %h/%h/%h expected 42/%h/%h", i,
                   log_dev[i], log_reg[i], log_data[i], exp_reg[i], exp_data[i]);
        end
      end
      checks++;
      if (req_cyc[0] - t0 != 2) begin
        errors++; $display("FAIL start_latency: got %0d expected 2", req_cyc[0] - t0);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (done_cyc.size() <= i || req_cyc[i+1] - done_cyc[i] != exp_gap[i]) begin
          errors++;
          $display("FAIL gap_after_entry%0d: got %0d expected %0d", i,
                   (done_cyc.size() > i) ? req_cyc[i+1] - done_cyc[i] : -1, exp_gap[i]);
        end
      end
    end
  endtask

  task automatic test_nack_retry();
    int t0;
    bit ok;
    bit bad;
    logic [7:0] exp[$];
    clear_logs();
    nack_reg = 8'h3A;
    nack_left = 2;
    pulse_start(t0);
    wait_end(800, ok);
`ifdef CAM_CFG_RETRY_EN
    exp = '{8'h12, 8'h11, 8'h3A, 8'h3A, 8'h3A, 8'h40};
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL nack_retry_status: got done %b error %b expected 1 0", done, error);
    end
`else
    exp = '{8'h12, 8'h11, 8'h3A};
    checks++;
    if (!ok || error !== 1'b1 || err_index !== 2'd2) begin
      errors++; $display("FAIL nack_error: got error %b err_index %0d expected 1 2", error, err_index);
    end
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wr_req !== 1'b0) bad = 1'b1;
    end
    #1;
    checks++;
    if (bad || log_reg.size() != 3) begin
      errors++; $display("FAIL nack_no_more_req: got req %b writes %0d expected 0 3", bad, log_reg.size());
    end
`endif
    checks++;
    bad = (log_reg.size() != exp.size());
    for (int i = 0; i < log_reg.size() && !bad; i++) if (log_reg[i] !== exp[i]) bad = 1'b1;
    if (bad) begin
      errors++; $display("FAIL nack_retry_sequence: got %0d writes expected %0d in table order",
                         log_reg.size(), exp.size());
    end
    nack_left = 0;
  endtask

  task automatic test_nack_exhaust();
    int t0;
    bit ok;
    int exp_n;
    clear_logs();
    nack_reg = 8'h11;
    nack_left = 4;
    pulse_start(t0);
    wait_end(800, ok);
`ifdef CAM_CFG_RETRY_EN
    exp_n = 5;
`else
    exp_n = 2;
`endif
    checks++;
    if (!ok || error !== 1'b1 || done !== 1'b0 || err_index !== 2'd1) begin
      errors++; $display("FAIL exhaust_error: got error %b done %b err_index %0d expected 1 0 1",
                         error, done, err_index);
    end
    checks++;
    if (log_reg.size() != exp_n || log_reg[log_reg.size()-1] !== 8'h11) begin
      errors++; $display("FAIL exhaust_attempts: got %0d writes expected %0d", log_reg.size(), exp_n);
    end
    nack_left = 0;
    clear_logs();
    pulse_start(t0);
    wait_end(500, ok);
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0 || log_reg.size() != 4 ||
        log_reg[0] !== 8'h12 || log_data[0] !== 8'h80) begin
      errors++; $display("FAIL restart_after_error: got done %b error %b writes %0d expected 1 0 4",
                         done, error, log_reg.size());
    end
    checks++;
    if (err_index !== 2'd1) begin
      errors++; $display("FAIL err_index_hold: got %0d expected 1", err_index);
    end
  endtask

  task automatic test_stall();
    int t0;
    bit ok;
    bit seen;
    int bad;
    logic [7:0] r, d;
    clear_logs();
    wr_ready = 1'b0;
    pulse_start(t0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = wr_req;
    end
    r = wr_reg;
    d = wr_data;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (wr_req !== 1'b1 || wr_reg !== r || wr_data !== d) bad++;
    end
    checks++;
    if (!seen || bad != 0 || r !== 8'h12 || d !== 8'h80) begin
      errors++; $display("FAIL stall_hold: got seen %b unstable %0d reg %h data %h expected 1 0 12 80",
                         seen, bad, r, d);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_req !== 1'b0 || log_reg.size() != 1) begin
      errors++; $display("FAIL stall_accept: got wr_req %b accepted %0d expected 0 1", wr_req, log_reg.size());
    end
    wait_end(500, ok);
    checks++;
    if (!ok || done !== 1'b1 || log_reg.size() != 4) begin
      errors++; $display("FAIL stall_complete: got done %b writes %0d expected 1 4", done, log_reg.size());
    end
  endtask

  task automatic test_sentinel();
    bit ok;
    @(posedge clk); #1;
    start_s = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL sentinel_busy: got %b expected 1", busy_s); end
    start_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = done_s;
    end
    checks++;
    if (!ok || nwr_s != 2 || busy_s !== 1'b0 || error_s !== 1'b0) begin
      errors++; $display("FAIL sentinel_stop: got done %b writes %0d expected 1 2", done_s, nwr_s);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bit ok;
    clear_logs();
    pulse_start(t0);
    for (int i = 0; i < 200 && done_cyc.size() < 2; i++) @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (done_cyc.size() != 2 || busy !== 1'b1 || wr_dev !== 8'h42) begin
      errors++; $display("FAIL reset_mid_setup: got acks %0d busy %b expected 2 1", done_cyc.size(), busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_req, busy, done, error} !== 4'b0000 || {wr_dev, wr_reg, wr_data} !== 24'h0 ||
        err_index !== 2'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got req/busy/done/error %b bus %h idx %0d expected 0000 0 0",
                         {wr_req, busy, done, error}, {wr_dev, wr_reg, wr_data}, err_index);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    pulse_start(t0);
    wait_end(500, ok);
    checks++;
    if (!ok || done !== 1'b1 || log_reg.size() != 4 || log_reg[0] !== 8'h12 || log_data[0] !== 8'h80) begin
      errors++; $display("FAIL reset_mid_restart: got done %b writes %0d expected 1 4 from entry 0",
                         done, log_reg.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_nack_retry();
    test_nack_exhaust();
    test_stall();
    test_sentinel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
